// File: rtl/even_parity_pkg.sv
// ---------------------------------------------------------------------------
// even_parity_pkg
//   Shared definitions for the even-parity receive path.
//
//   rx_state_t : receiver FSM states
//                  S_DATA - shifting in data bits, LSB first
//                  S_PAR  - waiting for the parity bit
//                  S_HOLD - word presented, waiting for the consumer
//   even_par() : even-parity bit of a vector (XOR of all bits). The
//                combinational generator and the receiver bench both use it,
//                so "generated parity" means the same thing on both ends.
//                Narrower vectors are zero-extended by the caller, which
//                leaves the XOR unchanged.
// ---------------------------------------------------------------------------
package even_parity_pkg;

    typedef enum logic [1:0] {
        S_DATA = 2'd0,
        S_PAR  = 2'd1,
        S_HOLD = 2'd2
    } rx_state_t;

    // Widest vector even_par() accepts.
    localparam int PAR_MAX_W = 64;

    function automatic logic even_par(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage : even_parity_pkg

// File: rtl/even_parity_sat_cnt.sv
// ---------------------------------------------------------------------------
// even_parity_sat_cnt
//   Saturating up-counter. Counts each cycle inc is high and sticks at
//   all-ones. Only the reset clears it.
//
//   Ports
//     clk    in   1   rising-edge clock
//     rst_n  in   1   asynchronous active-low reset (count -> 0)
//     inc    in   1   add one this cycle (ignored once saturated)
//     cnt    out  W   current count
// ---------------------------------------------------------------------------
module even_parity_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : even_parity_sat_cnt

// File: rtl/even_parity_checker_rx.sv
// ---------------------------------------------------------------------------
// even_parity_checker_rx
//   Serial receiver for even-parity protected frames. Each frame is DATA_W
//   data bits (LSB first) followed by one even-parity bit. The assembled word
//   and a parity-error flag are offered on a valid/ready output.
//
//   Parameters
//     DATA_W     data bits per frame (>= 2)
//     ERR_CNT_W  width of the saturating parity-error counter
//
//   Ports
//     clk        in   1          rising-edge clock
//     rst_n      in   1          asynchronous active-low reset
//     bit_in     in   1          serial data/parity bit
//     bit_vld    in   1          bit_in valid this cycle
//     frame_clr  in   1          synchronous abort of a partial frame
//     data_out   out  DATA_W     received word, bit0 = first bit received
//     par_err    out  1          odd number of ones over data+parity
//     out_vld    out  1          word available
//     out_rdy    in   1          consumer ready
//     overrun    out  1          one-cycle pulse: a bit arrived while holding
//     err_cnt    out  ERR_CNT_W  saturating count of accepted error words
//
//   Build option
//     PARITY_ERR_CNT_EN  when defined, err_cnt counts accepted words with
//                        par_err=1 (saturating, cleared only by rst_n).
//                        When undefined, err_cnt is tied to zero and no
//                        counter is built.
//
//   Output handshake: a word transfers on a rising edge where out_vld and
//   out_rdy are both high. Once raised, out_vld stays high and data_out /
//   par_err stay stable until that transfer; out_vld never depends on
//   out_rdy, and out_vld drops on the transfer edge.
// ---------------------------------------------------------------------------
module even_parity_checker_rx
    import even_parity_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic                 bit_vld,
    input  logic                 frame_clr,
    output logic [DATA_W-1:0]    data_out,
    output logic                 par_err,
    output logic                 out_vld,
    input  logic                 out_rdy,
    output logic                 overrun,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // bit_cnt counts up to DATA_W after the last data bit, so it needs one
    // value more than the data index range.
    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    rx_state_t         state_q,   state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shreg_q,   shreg_d;
    logic              acc_q,     acc_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              par_err_q, par_err_d;
    logic              out_vld_q, out_vld_d;
    logic              overrun_q, overrun_d;

    logic              handshake;

    assign handshake = out_vld_q && out_rdy;

    // -----------------------------------------------------------------------
    // Next-state and datapath
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        acc_d     = acc_q;
        data_d    = data_q;
        par_err_d = par_err_q;
        out_vld_d = out_vld_q;
        overrun_d = 1'b0;

        case (state_q)
            S_DATA: begin
                // frame_clr takes priority over a bit in the same cycle.
                if (frame_clr) begin
                    bit_cnt_d = '0;
                    acc_d     = 1'b0;
                end else if (bit_vld) begin
                    // Decoded write keeps the index inside the register
                    // even though bit_cnt is wider than the index range.
                    for (int i = 0; i < DATA_W; i++) begin
                        if (bit_cnt_q == CNT_W'(i)) begin
                            shreg_d[i] = bit_in;
                        end
                    end
                    acc_d     = acc_q ^ bit_in;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_IDX) begin
                        state_d = S_PAR;
                    end
                end
            end

            S_PAR: begin
                if (frame_clr) begin
                    bit_cnt_d = '0;
                    acc_d     = 1'b0;
                    state_d   = S_DATA;
                end else if (bit_vld) begin
                    data_d    = shreg_q;
                    // acc already holds the XOR of the data bits, so folding
                    // in the parity bit gives 1 exactly on an odd total.
                    par_err_d = acc_q ^ bit_in;
                    out_vld_d = 1'b1;
                    acc_d     = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = S_HOLD;
                end
            end

            S_HOLD: begin
                // Bits here are lost, including one arriving on the transfer
                // cycle; frame_clr is ignored so the held word survives.
                if (bit_vld) begin
                    overrun_d = 1'b1;
                end
                if (handshake) begin
                    out_vld_d = 1'b0;
                    state_d   = S_DATA;
                end
            end

            default: begin
                state_d   = S_DATA;
                bit_cnt_d = '0;
                acc_d     = 1'b0;
                out_vld_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_DATA;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            acc_q     <= 1'b0;
            data_q    <= '0;
            par_err_q <= 1'b0;
            out_vld_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            acc_q     <= acc_d;
            data_q    <= data_d;
            par_err_q <= par_err_d;
            out_vld_q <= out_vld_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_out = data_q;
    assign par_err  = par_err_q;
    assign out_vld  = out_vld_q;
    assign overrun  = overrun_q;

    // -----------------------------------------------------------------------
    // Parity-error counter
    // -----------------------------------------------------------------------
`ifdef PARITY_ERR_CNT_EN
    logic err_inc;

    // Count on the transfer edge, so a word that is never taken never counts.
    assign err_inc = handshake && par_err_q;

    even_parity_sat_cnt #(
        .W (ERR_CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (err_inc),
        .cnt   (err_cnt)
    );
`else
    assign err_cnt = '0;
`endif

endmodule : even_parity_checker_rx

// File: tb/tb_even_parity_checker_rx.sv
// ---------------------------------------------------------------------------
// tb_even_parity_checker_rx
//   Directed bench for even_parity_checker_rx. An 8-bit instance covers the
//   main receive path; a 3-bit instance with a 2-bit error counter receives
//   every output combination of the 3-input parity generator.
// ---------------------------------------------------------------------------
module tb_even_parity_checker_rx;
    import even_parity_pkg::*;

`ifdef PARITY_ERR_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit instance
    logic       bit_in8, bit_vld8, frame_clr8, out_rdy8;
    logic [7:0] data8;
    logic       par_err8, out_vld8, overrun8;
    logic [7:0] err_cnt8;

    // 3-bit instance
    logic       bit_in3, bit_vld3, frame_clr3, out_rdy3;
    logic [2:0] data3;
    logic       par_err3, out_vld3, overrun3;
    logic [1:0] err_cnt3;

    int total;
    int bad;
    int exp_err8;
    int exp_err3;

    even_parity_checker_rx #(
        .DATA_W    (8),
        .ERR_CNT_W (8)
    ) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in8),
        .bit_vld   (bit_vld8),
        .frame_clr (frame_clr8),
        .data_out  (data8),
        .par_err   (par_err8),
        .out_vld   (out_vld8),
        .out_rdy   (out_rdy8),
        .overrun   (overrun8),
        .err_cnt   (err_cnt8)
    );

    even_parity_checker_rx #(
        .DATA_W    (3),
        .ERR_CNT_W (2)
    ) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in3),
        .bit_vld   (bit_vld3),
        .frame_clr (frame_clr3),
        .data_out  (data3),
        .par_err   (par_err3),
        .out_vld   (out_vld3),
        .out_rdy   (out_rdy3),
        .overrun   (overrun3),
        .err_cnt   (err_cnt3)
    );

    // -----------------------------------------------------------------------
    // Driver tasks: inputs change on the falling edge, outputs are sampled
    // 1 time unit after the rising edge.
    // -----------------------------------------------------------------------
    task automatic send_bit8(input logic b);
        @(negedge clk);
        bit_vld8 = 1'b1;
        bit_in8  = b;
        @(posedge clk);
        #1;
        bit_vld8 = 1'b0;
        bit_in8  = 1'b0;
    endtask

    task automatic send_word8(input logic [7:0] w);
        for (int i = 0; i < 8; i++) begin
            send_bit8(w[i]);
        end
    endtask

    task automatic send_bit3(input logic b);
        @(negedge clk);
        bit_vld3 = 1'b1;
        bit_in3  = b;
        @(posedge clk);
        #1;
        bit_vld3 = 1'b0;
        bit_in3  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // -----------------------------------------------------------------------
    // Scenarios
    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst_n      = 1'b1;
        bit_in8    = 1'b0; bit_vld8 = 1'b0; frame_clr8 = 1'b0; out_rdy8 = 1'b1;
        bit_in3    = 1'b0; bit_vld3 = 1'b0; frame_clr3 = 1'b0; out_rdy3 = 1'b1;
        exp_err8   = 0;
        exp_err3   = 0;
        #1 rst_n = 1'b0;
        #2;
        total++;
        if ({data8, par_err8, out_vld8, overrun8, err_cnt8} !== 19'd0) begin
            bad++;
            $display("FAIL reset_dut8: got %h want 0",
                     {data8, par_err8, out_vld8, overrun8, err_cnt8});
        end
        total++;
        if ({data3, par_err3, out_vld3, overrun3, err_cnt3} !== 8'd0) begin
            bad++;
            $display("FAIL reset_dut3: got %h want 0",
                     {data3, par_err3, out_vld3, overrun3, err_cnt3});
        end
        idle_cycles(2);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(1);
    endtask

    task automatic test_basic_frame();
        out_rdy8 = 1'b1;
        send_word8(8'hA5);
        total++;
        if (out_vld8 !== 1'b0) begin
            bad++;
            $display("FAIL basic_early_vld: got %b want 0", out_vld8);
        end
        send_bit8(1'b0);
        total++;
        if ({out_vld8, data8, par_err8} !== {1'b1, 8'hA5, 1'b0}) begin
            bad++;
            $display("FAIL basic_word: vld/data/err got %b/%h/%b want 1/a5/0",
                     out_vld8, data8, par_err8);
        end
        idle_cycles(1);
        total++;
        if (out_vld8 !== 1'b0) begin
            bad++;
            $display("FAIL basic_vld_drop: got %b want 0", out_vld8);
        end
    endtask

    task automatic test_par_err();
        send_word8(8'h07);
        send_bit8(1'b0);
        total++;
        if ({out_vld8, data8, par_err8} !== {1'b1, 8'h07, 1'b1}) begin
            bad++;
            $display("FAIL perr_word: vld/data/err got %b/%h/%b want 1/07/1",
                     out_vld8, data8, par_err8);
        end
        total++;
        if (err_cnt8 !== 8'(exp_err8)) begin
            bad++;
            $display("FAIL perr_cnt_before: got %0d want %0d", err_cnt8, exp_err8);
        end
        idle_cycles(1);
        exp_err8 = exp_err8 + CNT_EN;
        total++;
        if ({out_vld8, err_cnt8} !== {1'b0, 8'(exp_err8)}) begin
            bad++;
            $display("FAIL perr_cnt_after: vld/cnt got %b/%0d want 0/%0d",
                     out_vld8, err_cnt8, exp_err8);
        end
    endtask

    task automatic test_overrun();
        out_rdy8 = 1'b0;
        send_word8(8'h5A);
        send_bit8(1'b0);
        total++;
        if ({out_vld8, data8, par_err8} !== {1'b1, 8'h5A, 1'b0}) begin
            bad++;
            $display("FAIL ovr_word: vld/data/err got %b/%h/%b want 1/5a/0",
                     out_vld8, data8, par_err8);
        end
        // Five stalled cycles, with a stray bit on every other one.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bit_vld8 = ((k % 2) == 0);
            bit_in8  = 1'b1;
            @(posedge clk);
            #1;
            bit_vld8 = 1'b0;
            bit_in8  = 1'b0;
            total++;
            if ({overrun8, out_vld8, data8, par_err8} !==
                {((k % 2) == 0), 1'b1, 8'h5A, 1'b0}) begin
                bad++;
                $display("FAIL ovr_hold%0d: ovr/vld/data/err got %b/%b/%h/%b want %b/1/5a/0",
                         k, overrun8, out_vld8, data8, par_err8, ((k % 2) == 0));
            end
        end
        // A bit on the transfer cycle is dropped as well.
        @(negedge clk);
        out_rdy8 = 1'b1;
        bit_vld8 = 1'b1;
        bit_in8  = 1'b1;
        @(posedge clk);
        #1;
        bit_vld8 = 1'b0;
        bit_in8  = 1'b0;
        total++;
        if ({out_vld8, overrun8} !== 2'b01) begin
            bad++;
            $display("FAIL ovr_handshake: vld/ovr got %b/%b want 0/1", out_vld8, overrun8);
        end
        send_word8(8'h3C);
        send_bit8(1'b0);
        total++;
        if ({out_vld8, data8, par_err8, overrun8} !== {1'b1, 8'h3C, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL ovr_next: vld/data/err/ovr got %b/%h/%b/%b want 1/3c/0/0",
                     out_vld8, data8, par_err8, overrun8);
        end
        idle_cycles(1);
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 4; i++) begin
            send_bit8(1'b1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_err8 = 0;
        exp_err3 = 0;
        total++;
        if ({data8, par_err8, out_vld8, overrun8, err_cnt8} !== 19'd0) begin
            bad++;
            $display("FAIL rstmid_async: got %h want 0",
                     {data8, par_err8, out_vld8, overrun8, err_cnt8});
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_word8(8'hFF);
        send_bit8(1'b0);
        total++;
        if ({out_vld8, data8, par_err8} !== {1'b1, 8'hFF, 1'b0}) begin
            bad++;
            $display("FAIL rstmid_word: vld/data/err got %b/%h/%b want 1/ff/0",
                     out_vld8, data8, par_err8);
        end
        idle_cycles(1);
    endtask

    task automatic test_frame_clr();
        // Clear in S_DATA after three ones, with a bit in the clear cycle.
        for (int i = 0; i < 3; i++) begin
            send_bit8(1'b1);
        end
        @(negedge clk);
        frame_clr8 = 1'b1;
        bit_vld8   = 1'b1;
        bit_in8    = 1'b1;
        @(posedge clk);
        #1;
        frame_clr8 = 1'b0;
        bit_vld8   = 1'b0;
        bit_in8    = 1'b0;
        total++;
        if (out_vld8 !== 1'b0) begin
            bad++;
            $display("FAIL clr_no_out: got %b want 0", out_vld8);
        end
        send_word8(8'h81);
        send_bit8(1'b0);
        total++;
        if ({out_vld8, data8, par_err8} !== {1'b1, 8'h81, 1'b0}) begin
            bad++;
            $display("FAIL clr_data_word: vld/data/err got %b/%h/%b want 1/81/0",
                     out_vld8, data8, par_err8);
        end
        idle_cycles(1);

        // Clear while waiting for the parity bit.
        out_rdy8 = 1'b0;
        send_word8(8'hFE);
        @(negedge clk);
        frame_clr8 = 1'b1;
        @(posedge clk);
        #1;
        frame_clr8 = 1'b0;
        send_word8(8'h81);
        send_bit8(1'b0);
        total++;
        if ({out_vld8, data8, par_err8} !== {1'b1, 8'h81, 1'b0}) begin
            bad++;
            $display("FAIL clr_par_word: vld/data/err got %b/%h/%b want 1/81/0",
                     out_vld8, data8, par_err8);
        end

        // Clear while holding is ignored.
        @(negedge clk);
        frame_clr8 = 1'b1;
        @(posedge clk);
        #1;
        frame_clr8 = 1'b0;
        total++;
        if ({out_vld8, data8} !== {1'b1, 8'h81}) begin
            bad++;
            $display("FAIL clr_hold: vld/data got %b/%h want 1/81", out_vld8, data8);
        end
        @(negedge clk);
        out_rdy8 = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_vld8 !== 1'b0) begin
            bad++;
            $display("FAIL clr_hold_release: got %b want 0", out_vld8);
        end
    endtask

    task automatic test_generator_combos();
        logic [2:0] w;
        logic       p;
        out_rdy3 = 1'b1;
        // Generated parity: always passes.
        for (int v = 0; v < 8; v++) begin
            w = v[2:0];
            p = even_par(64'(w));
            send_bit3(w[0]);
            send_bit3(w[1]);
            send_bit3(w[2]);
            send_bit3(p);
            total++;
            if ({out_vld3, data3, par_err3} !== {1'b1, w, 1'b0}) begin
                bad++;
                $display("FAIL gen_ok%0d: vld/data/err got %b/%h/%b want 1/%h/0",
                         v, out_vld3, data3, par_err3, w);
            end
            idle_cycles(1);
        end
        // Inverted parity: always fails; the 2-bit counter pins at 3.
        for (int v = 0; v < 8; v++) begin
            w = v[2:0];
            p = ~even_par(64'(w));
            send_bit3(w[0]);
            send_bit3(w[1]);
            send_bit3(w[2]);
            send_bit3(p);
            total++;
            if ({out_vld3, data3, par_err3} !== {1'b1, w, 1'b1}) begin
                bad++;
                $display("FAIL gen_bad%0d: vld/data/err got %b/%h/%b want 1/%h/1",
                         v, out_vld3, data3, par_err3, w);
            end
            idle_cycles(1);
            if (CNT_EN != 0 && exp_err3 < 3) begin
                exp_err3 = exp_err3 + 1;
            end
            total++;
            if (err_cnt3 !== 2'(exp_err3)) begin
                bad++;
                $display("FAIL gen_cnt%0d: got %0d want %0d", v, err_cnt3, exp_err3);
            end
        end
    endtask

    // -----------------------------------------------------------------------
    // Sequence and report
    // -----------------------------------------------------------------------
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic_frame();
        test_par_err();
        test_overrun();
        test_reset_mid_frame();
        test_frame_clr();
        test_generator_combos();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_even_parity_checker_rx
